// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB3 bus signals for apb_master_bridge.
// The master modport is the bridge's view; slave is the harness/peripheral side.
interface apb_master_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: accept -> SETUP -> ACCESS (waits on pready, optional timeout) -> RESP.
// Zero-wait response 3 cycles after accept; no new command until the held response is consumed.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               pclk,
  input  logic               prst,
  apb_master_bridge_if.master bus
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic                  psel, psel_nxt;
  logic                  penable, penable_nxt;
  logic                  pwrite, pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr, paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata, pwdata_nxt;
  logic                  rsp_valid, rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata, rsp_rdata_nxt;
  logic                  rsp_err, rsp_err_nxt;
  logic                  rsp_timeout, rsp_timeout_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  timeout_hit;

  // This ACCESS cycle is the last one allowed with pready low.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt == LIMIT_M1);

  always_comb begin
    state_nxt       = state;
    psel_nxt        = psel;
    penable_nxt     = penable;
    pwrite_nxt      = pwrite;
    paddr_nxt       = paddr;
    pwdata_nxt      = pwdata;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    cnt_nxt         = cnt;

    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          // The APB output registers double as the command latch.
          state_nxt  = SETUP;
          psel_nxt   = 1'b1;
          pwrite_nxt = bus.cmd_write;
          paddr_nxt  = bus.cmd_addr;
          pwdata_nxt = bus.cmd_write ? bus.cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (bus.pready || timeout_hit) begin
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          pwrite_nxt    = 1'b0;
          paddr_nxt     = '0;
          pwdata_nxt    = '0;
          cnt_nxt       = '0;
          // A ready on the limit cycle is a normal completion.
          if (bus.pready) begin
            rsp_err_nxt     = bus.pslverr;
            rsp_rdata_nxt   = pwrite ? '0 : bus.prdata;
            rsp_timeout_nxt = 1'b0;
          end else begin
            rsp_err_nxt     = 1'b1;
            rsp_rdata_nxt   = '0;
            rsp_timeout_nxt = 1'b1;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      paddr       <= paddr_nxt;
      pwdata      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      cnt         <= cnt_nxt;
    end
  end

  assign bus.cmd_ready   = (state == IDLE) && !prst;
  assign bus.psel        = psel;
  assign bus.penable     = penable;
  assign bus.pwrite      = pwrite;
  assign bus.paddr       = paddr;
  assign bus.pwdata      = pwdata;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rsp_rdata;
  assign bus.rsp_err     = rsp_err;
  assign bus.rsp_timeout = rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: APB phase sequencing, wait states, errors, timeout, backpressure, reset.
module tb_apb_master_bridge;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;

  logic pclk = 1'b0;
  logic prst = 1'b1;
  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_master_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk),
    .prst(prst),
    .bus (bus.master)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One full command: waits = ACCESS cycles with pready low before it rises,
  // hold = response cycles with rsp_ready low.
  task automatic run_txn(input string nm, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int waits, input logic perr,
                         input logic [DW-1:0] prd, input int hold, input int exp_cyc,
                         input logic [DW-1:0] exp_rd, input logic exp_err, input logic exp_to);
    int n;
    bit done;
    logic [DW-1:0] exp_pw;
    exp_pw = w ? wd : '0;
    n = 0;
    done = 0;
    chk({nm, "_idle_rdy"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.rsp_ready = (hold == 0);
    bus.pready    = 1'b1;           // must be ignored outside ACCESS
    bus.pslverr   = 1'b1;
    bus.prdata    = 32'hFFFF_FFFF;
    tick();
    bus.cmd_valid = 1'b0;
    chk({nm, "_setup_psel"}, bus.psel, 1);
    chk({nm, "_setup_pen"}, bus.penable, 0);
    chk({nm, "_setup_addr"}, bus.paddr, a);
    chk({nm, "_setup_wr"}, bus.pwrite, w);
    chk({nm, "_setup_wdat"}, bus.pwdata, exp_pw);
    chk({nm, "_setup_rdy"}, bus.cmd_ready, 0);
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (bus.rsp_valid) begin
        done = 1;
      end else begin
        n++;
        chk({nm, "_acc_psel"}, bus.psel, 1);
        chk({nm, "_acc_pen"}, bus.penable, 1);
        chk({nm, "_acc_addr"}, bus.paddr, a);
        chk({nm, "_acc_wr"}, bus.pwrite, w);
        chk({nm, "_acc_wdat"}, bus.pwdata, exp_pw);
        chk({nm, "_acc_rdy"}, bus.cmd_ready, 0);
        bus.pready  = (n > waits);
        bus.pslverr = (n > waits) ? perr : 1'b1;
        bus.prdata  = (n > waits) ? prd : 32'hFFFF_FFFF;
      end
    end
    chk({nm, "_rsp_seen"}, done, 1);
    chk({nm, "_acc_cycles"}, n, exp_cyc);
    bus.pready = 1'b0;
    chk({nm, "_rsp_rdata"}, bus.rsp_rdata, exp_rd);
    chk({nm, "_rsp_err"}, bus.rsp_err, exp_err);
    chk({nm, "_rsp_to"}, bus.rsp_timeout, exp_to);
    chk({nm, "_rsp_psel"}, bus.psel, 0);
    chk({nm, "_rsp_pen"}, bus.penable, 0);
    chk({nm, "_rsp_addr"}, bus.paddr, 0);
    chk({nm, "_rsp_wdat"}, bus.pwdata, 0);
    chk({nm, "_rsp_rdy"}, bus.cmd_ready, 0);
    for (int h = 1; h < hold; h++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 8'hEE;
      tick();
      chk({nm, "_hold_vld"}, bus.rsp_valid, 1);
      chk({nm, "_hold_rdata"}, bus.rsp_rdata, exp_rd);
      chk({nm, "_hold_err"}, bus.rsp_err, exp_err);
      chk({nm, "_hold_to"}, bus.rsp_timeout, exp_to);
      chk({nm, "_hold_rdy"}, bus.cmd_ready, 0);
      chk({nm, "_hold_psel"}, bus.psel, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk({nm, "_end_vld"}, bus.rsp_valid, 0);
    chk({nm, "_end_rdy"}, bus.cmd_ready, 1);
    chk({nm, "_end_psel"}, bus.psel, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    #12;
    chk("rst_psel", bus.psel, 0);
    chk("rst_pen", bus.penable, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_rsp_vld", bus.rsp_valid, 0);
    chk("rst_cmd_rdy", bus.cmd_ready, 0);
    prst = 1'b0;
    tick();
    chk("post_rst_rdy", bus.cmd_ready, 1);

    //      name     w     addr   wdata          waits perr prdata         hold cyc rdata          err  to
    run_txn("wr0",   1'b1, 8'h04, 32'hDEADBEEF, 0,    1'b0, 32'h0,         0,   1,  32'h0,         1'b0, 1'b0);
    run_txn("rdw2",  1'b0, 8'h08, 32'h0,        2,    1'b0, 32'h0000_00A5, 0,   3,  32'h0000_00A5, 1'b0, 1'b0);
    run_txn("wrerr", 1'b1, 8'h10, 32'h1234_0000, 0,   1'b1, 32'h0,         0,   1,  32'h0,         1'b1, 1'b0);
    run_txn("rderr", 1'b0, 8'h14, 32'h0,        1,    1'b1, 32'h0000_0077, 0,   2,  32'h0000_0077, 1'b1, 1'b0);
    run_txn("tmo",   1'b0, 8'h20, 32'h0,        1000, 1'b0, 32'h0,         0,   16, 32'h0,         1'b1, 1'b1);
    run_txn("tmo_wr",1'b1, 8'h22, 32'hAAAA_5555, 1000, 1'b0, 32'h0,        0,   16, 32'h0,         1'b1, 1'b1);
    run_txn("edge16",1'b0, 8'h24, 32'h0,        15,   1'b0, 32'h1234_5678, 0,   16, 32'h1234_5678, 1'b0, 1'b0);
    run_txn("hold",  1'b0, 8'h0C, 32'h0,        0,    1'b0, 32'h0000_5A5A, 5,   1,  32'h0000_5A5A, 1'b0, 1'b0);
    run_txn("after", 1'b1, 8'h30, 32'h0BAD_F00D, 0,   1'b0, 32'h0,         0,   1,  32'h0,         1'b0, 1'b0);

    // Reset in the middle of an ACCESS wait.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h40;
    bus.pready    = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid_pen_before", bus.penable, 1);
    #2;
    prst = 1'b1;
    #1;
    chk("mid_rst_psel", bus.psel, 0);
    chk("mid_rst_pen", bus.penable, 0);
    chk("mid_rst_rdy", bus.cmd_ready, 0);
    chk("mid_rst_vld", bus.rsp_valid, 0);
    tick();
    prst = 1'b0;
    bus.pready = 1'b1;
    tick();
    chk("rel_rdy", bus.cmd_ready, 1);
    chk("rel_vld", bus.rsp_valid, 0);
    tick();
    chk("rel_vld2", bus.rsp_valid, 0);
    chk("rel_psel", bus.psel, 0);
    run_txn("fresh", 1'b0, 8'h08, 32'h0, 1, 1'b0, 32'h0000_CAFE, 0, 2, 32'h0000_CAFE, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Single-outstanding APB initiator that converts a simple valid/ready command interface into compliant APB3 SETUP/ACCESS transfers. It drives the peripheral-side bus of our APB slave IPs (PWM, etc.) from a CPU/test-harness side. It waits on PREADY, returns PRDATA and PSLVERR through a held response channel, and aborts transfers that exceed a PREADY timeout.

Parameters:
DATA_WIDTH, 32, width of PWDATA/PRDATA and command/response data
ADDR_WIDTH, 8, width of PADDR and command address
TIMEOUT_CYCLES, 16, max consecutive ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
PCLK_i  in  1  clock; all logic on rising edge
PRST_i  in  1  asynchronous active-high reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid&ready
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_WIDTH  target address
cmd_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  response available
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes/timeouts)
rsp_err_o  out  1  PSLVERR captured, or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
PSEL_o  out  1  APB select
PENABLE_o  out  1  APB enable
PWRITE_o  out  1  APB direction
PADDR_o  out  ADDR_WIDTH  APB address
PWDATA_o  out  DATA_WIDTH  APB write data
PRDATA_i  in  DATA_WIDTH  APB read data
PREADY_i  in  1  APB ready
PSLVERR_i  in  1  APB error

Behaviour:
- Reset (PRST_i high, async): state=IDLE; PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, timeout counter all 0. cmd_ready_o forced 0 while PRST_i high.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs and response outputs registered.
- IDLE: cmd_ready_o=1. On cmd_valid_i: latch write/addr/wdata -> SETUP. APB outputs all 0.
- SETUP (exactly 1 cycle): PSEL_o=1, PENABLE_o=0, PADDR_o/PWRITE_o = latched values, PWDATA_o = latched wdata if write else 0 -> ACCESS.
- ACCESS: PSEL_o=1, PENABLE_o=1, PADDR/PWRITE/PWDATA held stable. Each cycle PREADY_i=0 increments counter.
  - PREADY_i=1: capture rsp_err_o=PSLVERR_i; rsp_rdata_o=PRDATA_i if read (PSLVERR irrelevant), else 0; rsp_timeout_o=0 -> RESP.
  - PREADY_i=0 and counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0): rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0 -> RESP.
  - PREADY_i=1 on the same cycle the limit would be reached: normal completion wins.
- On leaving ACCESS: PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o return to 0; counter cleared.
- RESP: rsp_valid_o=1, rsp_* held stable until rsp_ready_i=1 -> IDLE, rsp_valid_o=0 next cycle. cmd_ready_o=0 in SETUP/ACCESS/RESP; no new command accepted until IDLE.
- Latency: accept at edge N; SETUP during N+1; ACCESS during N+2; with zero-wait PREADY, rsp_valid_o high from N+3. Each PREADY wait cycle adds 1. Min command-to-command period 4 cycles with rsp_ready_i held high.
- Counter width $clog2(TIMEOUT_CYCLES+1), min 1; never wraps (cleared on ACCESS exit).
- Reset mid-transfer: bus released immediately, in-flight command and pending response discarded, no rsp_valid_o.
- PREADY_i, PRDATA_i, PSLVERR_i ignored outside ACCESS.

Test Plan:
- Zero-wait write addr=0x04 data=0xDEADBEEF, PREADY=1 -> one SETUP cycle then one ACCESS cycle with PADDR=0x04, PWRITE=1, PWDATA=0xDEADBEEF; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read addr=0x08, PREADY low 2 ACCESS cycles then high with PRDATA=0x0000_00A5 -> PENABLE high 3 cycles, PADDR stable; rsp_rdata=0xA5, rsp_err=0.
- Write with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0.
- TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 ACCESS cycles, PSEL/PENABLE drop, rsp_err=1, rsp_timeout=1, rsp_rdata=0; PREADY rising on 16th cycle instead -> normal completion.
- rsp_ready_i held 0 for 5 cycles with cmd_valid_i high -> rsp fields stable, cmd_ready_o=0 throughout; second command accepted only in IDLE after rsp handshake.
- PRST_i asserted during ACCESS -> same-cycle PSEL=PENABLE=0, no response; after release, cmd_ready_o=1 and fresh read completes normally.
